dpu_core: RTL and testbench



---
 rtl/dpu_core.sv | 85 ++++++++
 tb/tb_dpu_core.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dpu_core.sv
// Pixel data processing unit: 16 x RGB888 registers,
// one saturating per-channel op per clock, registered k/cc.
module dpu_core (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  Abus,
   input  logic [3:0]  Bbus,
   input  logic [3:0]  Rbus,
   input  logic [2:0]  n,
   output logic [3:0]  cc,
   output logic [23:0] k
);

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_LDI = 3'd4,
      OP_AVG = 3'd5,
      OP_MOV = 3'd6,
      OP_RD  = 3'd7
   } op_e;

   op_e         op;
   logic [23:0] regs [16];
   logic [23:0] a, b, res;
   logic [23:0] add_px, sub_px, avg_px;
   logic [2:0]  add_c, sub_c;
   logic        carry;
   logic [7:0]  imm;

   assign op  = op_e'(n);
   assign a   = regs[Abus];
   assign b   = regs[Bbus];
   assign imm = {Abus, Bbus};

   // 9-bit per-channel lanes; no carry crosses a channel
   for (genvar i = 0; i < 3; i++) begin : g_ch
      logic [8:0] sum, dif;
      assign sum = {1'b0, a[8*i+:8]} + {1'b0, b[8*i+:8]};
      assign dif = {1'b0, a[8*i+:8]} - {1'b0, b[8*i+:8]};
      assign add_px[8*i+:8] = sum[8] ? 8'hFF : sum[7:0];
      assign sub_px[8*i+:8] = dif[8] ? 8'h00 : dif[7:0];
      assign avg_px[8*i+:8] = sum[8:1];
      assign add_c[i] = sum[8];
      assign sub_c[i] = dif[8];
   end

   always_comb begin
      res   = a;
      carry = 1'b0;
      unique case (op)
         OP_ADD: begin
            res   = add_px;
            carry = |add_c;
         end
         OP_SUB: begin
            res   = sub_px;
            carry = |sub_c;
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_LDI: res = {imm, imm, imm};
         OP_AVG: res = avg_px;
         OP_MOV: res = a;
         OP_RD:  res = a;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++)
            regs[i] <= 24'h0;
         k  <= 24'h0;
         cc <= 4'h0;
      end else begin
         k  <= res;
         cc <= {res[23], res == 24'h0, carry, a == b};
         if (op != OP_RD)
            regs[Rbus] <= res;
      end
   end

endmodule

// File: tb/tb_dpu_core.sv
// Scoreboard bench for dpu_core: behavioural pixel model
// feeds an expected queue, compared one cycle after issue.
module tb_dpu_core;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  Abus, Bbus, Rbus;
   logic [2:0]  n;
   logic [3:0]  cc;
   logic [23:0] k;

   int n_chk  = 0;
   int n_fail = 0;

   logic [27:0] exp_q [$];
   logic [23:0] mreg [16];
   logic [27:0] last;

   dpu_core dut (
      .clk  (clk),
      .rst  (rst),
      .Abus (Abus),
      .Bbus (Bbus),
      .Rbus (Rbus),
      .n    (n),
      .cc   (cc),
      .k    (k)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [27:0] got,
                      input logic [27:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got k=%h cc=%b, want k=%h cc=%b",
                  tag, got[27:4], got[3:0], exp[27:4], exp[3:0]);
      end
   endtask

   function automatic logic [27:0] model(input logic [2:0] op,
                                         input logic [3:0] ai,
                                         input logic [3:0] bi);
      logic [23:0] x, y, r;
      logic        c;
      int          s;
      x = mreg[ai];
      y = mreg[bi];
      r = x;
      c = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
         case (op)
            3'd0: begin
               s = int'(x[8*ch+:8]) + int'(y[8*ch+:8]);
               if (s > 255) begin s = 255; c = 1'b1; end
               r[8*ch+:8] = s[7:0];
            end
            3'd1: begin
               s = int'(x[8*ch+:8]) - int'(y[8*ch+:8]);
               if (s < 0) begin s = 0; c = 1'b1; end
               r[8*ch+:8] = s[7:0];
            end
            3'd2: r[8*ch+:8] = x[8*ch+:8] & y[8*ch+:8];
            3'd3: r[8*ch+:8] = x[8*ch+:8] | y[8*ch+:8];
            3'd4: r[8*ch+:8] = {ai, bi};
            3'd5: begin
               s = (int'(x[8*ch+:8]) + int'(y[8*ch+:8])) / 2;
               r[8*ch+:8] = s[7:0];
            end
            default: r[8*ch+:8] = x[8*ch+:8];
         endcase
      end
      return {r, r[23], r == 24'h0, c, x == y};
   endfunction

   task automatic op(input string tag, input logic [2:0] nn,
                     input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] r, input logic rs);
      logic [27:0] e;
      @(negedge clk);
      rst  = rs;
      n    = nn;
      Abus = a;
      Bbus = b;
      Rbus = r;
      if (rs) begin
         e = 28'h0;
         for (int i = 0; i < 16; i++) mreg[i] = 24'h0;
      end else begin
         e = model(nn, a, b);
         if (nn != 3'd7) mreg[r] = e[27:4];
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      last = {k, cc};
      if (exp_q.size() == 0) begin
         chk({tag, "_q"}, last, 28'hxxxxxxx);
      end else begin
         chk(tag, last, exp_q.pop_front());
      end
   endtask

   initial begin
      rst = 1'b1; n = 3'd7; Abus = 0; Bbus = 0; Rbus = 0;

      op("rst", 3'd7, 4'h0, 4'h0, 4'h0, 1'b1);
      chk("rst_c", last, 28'h0);
      op("add0", 3'd0, 4'hA, 4'h8, 4'h9, 1'b0);
      chk("add0_c", last, {24'h000000, 4'b0101});

      op("ldi3a", 3'd4, 4'h3, 4'hA, 4'hA, 1'b0);
      chk("ldi3a_c", last, {24'h3A3A3A, 4'b0001});
      op("rda", 3'd7, 4'hA, 4'h0, 4'h0, 1'b0);
      chk("rda_c", last, {24'h3A3A3A, 4'b0000});

      op("ldif0", 3'd4, 4'hF, 4'h0, 4'h1, 1'b0);
      op("ldi20", 3'd4, 4'h2, 4'h0, 4'h2, 1'b0);
      op("addsat", 3'd0, 4'h1, 4'h2, 4'h3, 1'b0);
      chk("addsat_c", last, {24'hFFFFFF, 4'b1010});
      op("subsat", 3'd1, 4'h2, 4'h1, 4'h6, 1'b0);
      chk("subsat_c", last, {24'h000000, 4'b0110});

      op("ldi11", 3'd4, 4'h1, 4'h1, 4'h4, 1'b0);
      op("b2b", 3'd0, 4'h4, 4'h4, 4'h4, 1'b0);
      chk("b2b_c", last, {24'h222222, 4'b0001});
      op("rd4", 3'd7, 4'h4, 4'h0, 4'h0, 1'b0);
      chk("rd4_c", last, {24'h222222, 4'b0000});

      op("ldiff", 3'd4, 4'hF, 4'hF, 4'h7, 1'b0);
      op("ldi01", 3'd4, 4'h0, 4'h1, 4'h8, 1'b0);
      op("avg", 3'd5, 4'h7, 4'h8, 4'h9, 1'b0);
      chk("avg_c", last, {24'h808080, 4'b1000});
      op("addff0", 3'd0, 4'h7, 4'h0, 4'hA, 1'b0);
      chk("addff0_c", last, {24'hFFFFFF, 4'b1000});
      op("sub01", 3'd1, 4'h0, 4'h8, 4'hB, 1'b0);
      chk("sub01_c", last, {24'h000000, 4'b0110});
      op("avgff", 3'd5, 4'h7, 4'h7, 4'hC, 1'b0);
      chk("avgff_c", last, {24'hFFFFFF, 4'b1001});
      op("ldi55", 3'd4, 4'h5, 4'h5, 4'hF, 1'b0);
      op("rdf", 3'd7, 4'hF, 4'hF, 4'h0, 1'b0);
      chk("rdf_c", last, {24'h555555, 4'b0001});

      op("ldirst", 3'd4, 4'h1, 4'h2, 4'h5, 1'b1);
      chk("ldirst_c", last, 28'h0);
      op("rd5", 3'd7, 4'h5, 4'h0, 4'h0, 1'b0);
      chk("rd5_c", last, {24'h000000, 4'b0101});

      for (int i = 0; i < 400; i++) begin
         op("rand", 3'($urandom_range(7, 0)),
            4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
            4'($urandom_range(15, 0)), $urandom_range(49, 0) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
